// File: rtl/avmm_sdram_write_wrapper_if.sv
// ---------------------------------------------------------------------------
// avmm_sdram_write_wrapper_if
//
// Purpose : Avalon-MM burst-write bus between the write wrapper (master) and
//           the SDRAM controller (slave).
// Params  : SDRAM_DATA_W - data width in bits. It must match the wrapper's
//           SDRAM_DATA_W.
// Signals : address     - byte address of the current burst
//           burstcount  - beats in the current burst
//           write       - write strobe
//           writedata   - beat data
//           byteenable  - byte lanes of the beat
//           waitrequest - slave stall
// ---------------------------------------------------------------------------
interface avmm_sdram_write_wrapper_if #(
    parameter int SDRAM_DATA_W = 128
);
    localparam int BYTES = SDRAM_DATA_W / 8;

    logic [31:0]             address;
    logic [10:0]             burstcount;
    logic                    write;
    logic [SDRAM_DATA_W-1:0] writedata;
    logic [BYTES-1:0]        byteenable;
    logic                    waitrequest;

    modport master (
        output address, burstcount, write, writedata, byteenable,
        input  waitrequest
    );

    modport slave (
        input  address, burstcount, write, writedata, byteenable,
        output waitrequest
    );
endinterface

// File: rtl/avmm_sdram_write_wrapper.sv
// ---------------------------------------------------------------------------
// avmm_sdram_write_wrapper
//
// Purpose : Turns a streaming write request into Avalon-MM burst writes. The
//           request is a start byte address, a beat count and a valid/ready
//           data stream. Long transfers are split into bursts of at most
//           MAX_BURST beats. write_done pulses once, after the slave accepts
//           the last beat.
//
// Ports   : clk, rst_n       - clock and asynchronous active-low reset
//           avm (master)     - Avalon-MM write bus (address, burstcount,
//                              write, writedata, byteenable, waitrequest)
//           write_addr/cnt   - transfer start address and beat count; both
//                              are sampled with write_start
//           write_start      - one-cycle request strobe
//           write_data/valid - client beat stream; write_ready is its ready
//           write_be         - client byte enables (optional port)
//           write_done       - one-cycle completion pulse
//           busy             - high from the accepted start until write_done
//
// Config  : define AVMM_WR_BYTEENABLE_EN to add write_be. write_be is
//           registered with the beat data and driven on byteenable.
//           Without the macro, byteenable is tied to all-ones.
// ---------------------------------------------------------------------------
module avmm_sdram_write_wrapper #(
    parameter int SDRAM_DATA_W = 128,
    parameter int MAX_BURST    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    avmm_sdram_write_wrapper_if.master    avm,
    input  logic [31:0]                   write_addr,
    input  logic [31:0]                   write_cnt,
    input  logic                          write_start,
    input  logic [SDRAM_DATA_W-1:0]       write_data,
`ifdef AVMM_WR_BYTEENABLE_EN
    input  logic [SDRAM_DATA_W/8-1:0]     write_be,
`endif
    input  logic                          write_valid,
    output logic                          write_ready,
    output logic                          write_done,
    output logic                          busy
);
    localparam int BYTES = SDRAM_DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

    state_t                  state_q;
    logic [31:0]             rem_q;        // beats not yet accepted by the slave
    logic [10:0]             burst_len_q;  // beats in the current burst
    logic [10:0]             loaded_q;     // beats of this burst taken from the client
    logic [10:0]             acked_q;      // beats of this burst accepted by the slave
    logic [31:0]             address_q;
    logic [10:0]             burstcount_q;
    logic                    write_q;
    logic [SDRAM_DATA_W-1:0] writedata_q;
    logic [BYTES-1:0]        be_q;
    logic                    done_q;
    logic                    busy_q;

    // Beats in the next burst: the smaller of the remaining count and MAX_BURST.
    function automatic logic [10:0] clip_len(input logic [31:0] n);
        if (n > 32'(MAX_BURST)) return 11'(MAX_BURST);
        return n[10:0];
    endfunction

    logic        in_burst;
    logic        accept;
    logic        last_accept;
    logic [31:0] rem_left_d;
    logic        more_d;
    logic        hs;

    assign in_burst    = (state_q == S_BURST);
    assign accept      = in_burst && write_q && !avm.waitrequest;
    assign last_accept = accept && (acked_q == burst_len_q - 11'd1);
    assign rem_left_d  = rem_q - {21'd0, burst_len_q};
    assign more_d      = (rem_left_d != 32'd0);

    // When the last beat of a burst leaves, the first beat of the next burst
    // can be loaded on the same edge. This keeps throughput at one beat per
    // cycle across burst boundaries.
    assign write_ready = in_burst && (!write_q || !avm.waitrequest) &&
                         ((loaded_q < burst_len_q) || (last_accept && more_d));
    assign hs          = write_valid && write_ready;

    // NOTE: state lives in one clocked block and is assigned only with <=.
    // Every read in the block therefore sees the value from before the edge.
    // NOTE: the reset clears control and output registers only. The data
    // register needs no reset for correctness; it is cleared here only
    // because writedata has a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            burst_len_q  <= '0;
            loaded_q     <= '0;
            acked_q      <= '0;
            address_q    <= '0;
            burstcount_q <= '0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            be_q         <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (write_start) begin
                        busy_q       <= 1'b1;
                        rem_q        <= write_cnt;
                        address_q    <= write_addr;
                        burst_len_q  <= clip_len(write_cnt);
                        burstcount_q <= clip_len(write_cnt);
                        loaded_q     <= '0;
                        acked_q      <= '0;
                        if (write_cnt == 32'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_BURST;
                        end
                    end
                end

                S_BURST: begin
                    // Output register: a load wins over the slave draining it.
                    if (hs) begin
                        write_q     <= 1'b1;
                        writedata_q <= write_data;
`ifdef AVMM_WR_BYTEENABLE_EN
                        be_q        <= write_be;
`endif
                    end else if (accept) begin
                        write_q <= 1'b0;
                    end

                    if (last_accept) begin
                        rem_q   <= rem_left_d;
                        acked_q <= '0;
                        if (more_d) begin
                            address_q    <= address_q + 32'(burst_len_q) * 32'(BYTES);
                            burst_len_q  <= clip_len(rem_left_d);
                            burstcount_q <= clip_len(rem_left_d);
                            loaded_q     <= hs ? 11'd1 : 11'd0;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        if (accept) acked_q  <= acked_q + 11'd1;
                        if (hs)     loaded_q <= loaded_q + 11'd1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign avm.address    = address_q;
    assign avm.burstcount = burstcount_q;
    assign avm.write      = write_q;
    assign avm.writedata  = writedata_q;
`ifdef AVMM_WR_BYTEENABLE_EN
    assign avm.byteenable = be_q;
`else
    assign avm.byteenable = '1;
`endif
    assign write_done     = done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_avmm_sdram_write_wrapper.sv
module tb_avmm_sdram_write_wrapper;
    localparam int DW    = 128;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   write_addr = '0;
    logic [31:0]   write_cnt = '0;
    logic          write_start = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          write_valid = 1'b0;
    logic          write_ready;
    logic          write_done;
    logic          busy;
`ifdef AVMM_WR_BYTEENABLE_EN
    logic [BYTES-1:0] write_be = '1;
    localparam logic [BYTES-1:0] BE_RESET = '0;
`else
    localparam logic [BYTES-1:0] BE_RESET = '1;
`endif

    avmm_sdram_write_wrapper_if #(.SDRAM_DATA_W(DW)) avm ();

    avmm_sdram_write_wrapper #(.SDRAM_DATA_W(DW), .MAX_BURST(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .avm         (avm),
        .write_addr  (write_addr),
        .write_cnt   (write_cnt),
        .write_start (write_start),
        .write_data  (write_data),
`ifdef AVMM_WR_BYTEENABLE_EN
        .write_be    (write_be),
`endif
        .write_valid (write_valid),
        .write_ready (write_ready),
        .write_done  (write_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tag;
    logic [31:0]   q_addr[$];
    logic [10:0]   q_bc[$];
    logic [DW-1:0] q_data[$];
    bit            q_wr[$];
    int  done_cyc, last_acc_cyc, stall_cycles, stall_bad;
    bit  done_seen;
    logic busy_at0;

    function automatic logic [DW-1:0] mkdata(input int i);
        logic [31:0] iv;
        iv = i;
        return {tag, iv, ~iv, 32'hC0DE_0000 ^ iv};
    endfunction

    // Reference model for beat i of a transfer (MAX_BURST = 64, 16 bytes per beat).
    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
        return base + 32'((i / 64) * 64 * BYTES);
    endfunction

    function automatic logic [10:0] exp_bc(input int n, input int i);
        int r;
        r = n - (i / 64) * 64;
        return (r > 64) ? 11'd64 : 11'(r);
    endfunction

    // Runs one transfer from posedge+1. Client and slave are both driven just
    // after each rising edge; everything is observed on the falling edge.
    task automatic drive(input logic [31:0] addr, input logic [31:0] cnt, input bit gappy,
                         input int stall_beat, input int restart_at, input int abort_at,
                         input int max_cyc);
        int sent, acc, stall_left, cyc;
        q_addr.delete(); q_bc.delete(); q_data.delete(); q_wr.delete();
        done_seen = 0; done_cyc = -1; last_acc_cyc = -1; stall_cycles = 0; stall_bad = 0;
        busy_at0 = 1'bx;
        write_addr = addr; write_cnt = cnt; write_start = 1'b1;
        @(posedge clk); #1;
        write_start = 1'b0;
        sent = 0; acc = 0; stall_left = 3; cyc = 0;
        while (!done_seen && cyc < max_cyc && !(abort_at >= 0 && acc >= abort_at)) begin
            write_start = (cyc == restart_at);
            if (cyc == restart_at) begin
                write_addr = 32'h3000_0000;
                write_cnt  = 32'd2;
            end
            write_valid = (32'(sent) < cnt) && (!gappy || (cyc % 2 == 0));
            write_data  = mkdata(sent);
            avm.waitrequest = (stall_beat >= 0) && avm.write && (acc == stall_beat) && (stall_left > 0);
            @(negedge clk);
            if (cyc == 0) busy_at0 = busy;
            q_wr.push_back(avm.write);
            if (avm.waitrequest) begin
                stall_left--;
                stall_cycles++;
                if (write_ready !== 1'b0 || avm.write !== 1'b1 ||
                    avm.writedata !== mkdata(stall_beat) || avm.address !== addr)
                    stall_bad++;
            end
            if (write_done === 1'b1) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            if (write_valid && write_ready) sent++;
            if (avm.write === 1'b1 && !avm.waitrequest) begin
                q_addr.push_back(avm.address);
                q_bc.push_back(avm.burstcount);
                q_data.push_back(avm.writedata);
                acc++;
                last_acc_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        write_valid = 1'b0; write_start = 1'b0; avm.waitrequest = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        avm.waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (avm.address !== 32'd0) begin n_fail++; $display("FAIL reset_address: got %h want 0", avm.address); end
        n_checks++; if (avm.burstcount !== 11'd0) begin n_fail++; $display("FAIL reset_burstcount: got %0d want 0", avm.burstcount); end
        n_checks++; if (avm.write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", avm.write); end
        n_checks++; if (avm.writedata !== '0) begin n_fail++; $display("FAIL reset_writedata: got %h want 0", avm.writedata); end
        n_checks++; if (avm.byteenable !== BE_RESET) begin n_fail++; $display("FAIL reset_byteenable: got %h want %h", avm.byteenable, BE_RESET); end
        n_checks++; if (write_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", write_ready); end
        n_checks++; if (write_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", write_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_burst;
        tag = 32'h1111_0001;
        drive(32'h2000_0000, 32'd4, 1'b0, -1, -1, -1, 50);
        n_checks++; if (busy_at0 !== 1'b1) begin n_fail++; $display("FAIL single_busy_start: got %b want 1", busy_at0); end
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL single_beats: got %0d want 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== mkdata(i) || q_addr[i] !== 32'h2000_0000 || q_bc[i] !== 11'd4) begin
                n_fail++;
                $display("FAIL single_beat%0d: got addr %h bc %0d data %h want addr 20000000 bc 4 data %h",
                         i, q_addr[i], q_bc[i], q_data[i], mkdata(i));
            end
        end
        n_checks++; if (last_acc_cyc != 4) begin n_fail++; $display("FAIL single_last_accept_cycle: got %0d want 4", last_acc_cyc); end
        n_checks++; if (done_cyc != 5) begin n_fail++; $display("FAIL single_done_cycle: got %0d want 5", done_cyc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_multi_burst;
        int extra_done;
        tag = 32'h2222_0002;
        drive(32'h2000_0000, 32'd130, 1'b0, -1, -1, -1, 400);
        n_checks++; if (q_data.size() != 130) begin n_fail++; $display("FAIL multi_beats: got %0d want 130", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 130; i++) begin
            n_checks++;
            if (q_data[i] !== mkdata(i) || q_addr[i] !== exp_addr(32'h2000_0000, i) || q_bc[i] !== exp_bc(130, i)) begin
                n_fail++;
                $display("FAIL multi_beat%0d: got addr %h bc %0d data %h want addr %h bc %0d data %h",
                         i, q_addr[i], q_bc[i], q_data[i], exp_addr(32'h2000_0000, i), exp_bc(130, i), mkdata(i));
            end
        end
        if (q_data.size() == 130) begin
            n_checks++; if (q_addr[64] !== 32'h2000_0400 || q_bc[64] !== 11'd64) begin n_fail++; $display("FAIL multi_burst2: got %h/%0d want 20000400/64", q_addr[64], q_bc[64]); end
            n_checks++; if (q_addr[128] !== 32'h2000_0800 || q_bc[128] !== 11'd2) begin n_fail++; $display("FAIL multi_burst3: got %h/%0d want 20000800/2", q_addr[128], q_bc[128]); end
        end
        // Full throughput across both boundaries: 130 beats accepted in cycles 1..130.
        n_checks++; if (done_cyc != 131) begin n_fail++; $display("FAIL multi_done_cycle: got %0d want 131", done_cyc); end
        extra_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (write_done === 1'b1) extra_done++;
        end
        @(posedge clk); #1;
        n_checks++; if (extra_done != 0) begin n_fail++; $display("FAIL multi_single_done: got %0d extra pulses want 0", extra_done); end
    endtask

    task automatic test_waitrequest;
        tag = 32'h3333_0003;
        drive(32'h2000_1000, 32'd4, 1'b0, 1, -1, -1, 50);
        n_checks++; if (stall_cycles != 3) begin n_fail++; $display("FAIL stall_cycles: got %0d want 3", stall_cycles); end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); end
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL stall_beats: got %0d want 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== mkdata(i)) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", i, q_data[i], mkdata(i)); end
        end
        n_checks++; if (last_acc_cyc != 7 || done_cyc != 8) begin n_fail++; $display("FAIL stall_timing: got last %0d done %0d want 7/8", last_acc_cyc, done_cyc); end
    endtask

    task automatic test_gaps;
        bit [7:0] got_wr;
        tag = 32'h4444_0004;
        // A second write_start arrives at cycle 2 while busy and must be ignored.
        drive(32'h2000_2000, 32'd4, 1'b1, -1, 2, -1, 50);
        got_wr = '0;
        for (int k = 0; k < 8 && k < q_wr.size(); k++) got_wr[k] = q_wr[k];
        n_checks++; if (got_wr !== 8'b1010_1010) begin n_fail++; $display("FAIL gaps_write_pattern: got %b want 10101010", got_wr); end
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL gaps_beats: got %0d want 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== mkdata(i) || q_addr[i] !== 32'h2000_2000 || q_bc[i] !== 11'd4) begin
                n_fail++;
                $display("FAIL gaps_beat%0d: got addr %h bc %0d data %h want addr 20002000 bc 4 data %h",
                         i, q_addr[i], q_bc[i], q_data[i], mkdata(i));
            end
        end
        n_checks++; if (done_cyc != 8) begin n_fail++; $display("FAIL gaps_done_cycle: got %0d want 8", done_cyc); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || avm.write !== 1'b0) begin n_fail++; $display("FAIL gaps_restart_ignored: got busy %b write %b want 0/0", busy, avm.write); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_count;
        int wr_high;
        tag = 32'h5555_0005;
        drive(32'h2000_3000, 32'd0, 1'b0, -1, -1, -1, 20);
        wr_high = 0;
        foreach (q_wr[k]) if (q_wr[k]) wr_high++;
        n_checks++; if (busy_at0 !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", busy_at0); end
        n_checks++; if (done_cyc != 0) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 0", done_cyc); end
        n_checks++; if (wr_high != 0 || q_data.size() != 0) begin n_fail++; $display("FAIL zero_no_write: got %0d write cycles want 0", wr_high); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        tag = 32'h6666_0006;
        drive(32'h2000_4000, 32'd64, 1'b0, -1, -1, 10, 200);
        n_checks++; if (q_data.size() != 10) begin n_fail++; $display("FAIL abort_beats: got %0d want 10", q_data.size()); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (avm.address !== 32'd0 || avm.burstcount !== 11'd0) begin n_fail++; $display("FAIL abort_addr_bc: got %h/%0d want 0/0", avm.address, avm.burstcount); end
        n_checks++; if (avm.write !== 1'b0 || avm.writedata !== '0) begin n_fail++; $display("FAIL abort_write: got %b/%h want 0/0", avm.write, avm.writedata); end
        n_checks++; if (write_ready !== 1'b0 || write_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl: got ready %b done %b busy %b want 0/0/0", write_ready, write_done, busy); end
        n_checks++; if (avm.byteenable !== BE_RESET) begin n_fail++; $display("FAIL abort_byteenable: got %h want %h", avm.byteenable, BE_RESET); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tag = 32'h7777_0007;
        drive(32'h2000_5000, 32'd4, 1'b0, -1, -1, -1, 50);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL recover_beats: got %0d want 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== mkdata(i) || q_addr[i] !== 32'h2000_5000) begin
                n_fail++;
                $display("FAIL recover_beat%0d: got addr %h data %h want addr 20005000 data %h", i, q_addr[i], q_data[i], mkdata(i));
            end
        end
        n_checks++; if (done_cyc != 5) begin n_fail++; $display("FAIL recover_done_cycle: got %0d want 5", done_cyc); end
    endtask

    initial begin
        tag = '0;
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_waitrequest();
        test_gaps();
        test_zero_count();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
